// File: rtl/uart_pkg.sv
// Shared definitions for the UART autobaud controller: FSM states and
// the constants describing the 0x55 sync character measurement.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_START = 3'd2,
    MEASURE    = 3'd3,
    STOP_CHK   = 3'd4,
    LOCK       = 3'd5,
    FAIL       = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_CHAR     = 8'h55;
  localparam int         SYNC_EDGES    = 5;
  localparam int         BITS_MEASURED = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw RX line plus a falling-edge detector
// built from the synchronized value and its one-cycle-old copy.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle line is high, so the chain resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: measures a 0x55 sync character on RX, derives the
// baud generator divisor and sequences the generator enable around loads.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int OSR_LOG2 = 4,
  parameter int GUARD    = 16,
  parameter int CNT_W    = DIV_W + 3 + OSR_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             start,
  input  logic             manual_wr,
  input  logic [DIV_W-1:0] manual_div,
  output logic [DIV_W-1:0] divisor,
  output logic             baud_en,
  output logic             locked,
  output logic             busy,
  output logic             err
);

  localparam int MEAS_SHIFT = $clog2(BITS_MEASURED);
  localparam int S          = MEAS_SHIFT + OSR_LOG2;
  localparam int GW         = $clog2(GUARD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   HALF    = {{CNT_W{1'b0}}, 1'b1} << (S - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  state_e           state_q, state_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic [2:0]       edges_q, edges_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             baud_en_q, baud_en_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             en_pend_q, en_pend_d;
  logic             div_valid_q, div_valid_d;

  logic [CNT_W:0]   rnd_s;
  logic             q_ok_s;
  logic [CNT_W-1:0] stop_t_s;

  // meas spans 8 bit times; rounding to bit time in oversampled clocks.
  assign rnd_s    = ({1'b0, meas_q} + HALF) >> S;
  assign q_ok_s   = (rnd_s != '0) && (rnd_s[CNT_W:DIV_W] == '0);
  assign stop_t_s = (meas_q >> MEAS_SHIFT) + (meas_q >> (MEAS_SHIFT + 1));

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    cnt_d       = cnt_q;
    meas_d      = meas_q;
    edges_d     = edges_q;
    divisor_d   = divisor_q;
    baud_en_d   = baud_en_q;
    locked_d    = locked_q;
    busy_d      = busy_q;
    err_d       = err_q;
    en_pend_d   = 1'b0;
    div_valid_d = div_valid_q;

    // Divisor loaded last cycle: the generator may run again from now on.
    if (en_pend_q) begin
      baud_en_d = 1'b1;
      locked_d  = 1'b1;
    end else begin
      en_pend_d = 1'b0;
    end

    if (manual_wr) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      if (manual_div != '0) begin
        err_d       = 1'b0;
        baud_en_d   = 1'b0;
        divisor_d   = manual_div;
        en_pend_d   = 1'b1;
        div_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = ARM;
            busy_d    = 1'b1;
            baud_en_d = 1'b0;
            locked_d  = 1'b0;
            err_d     = 1'b0;
            guard_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        ARM: begin
          if (!rx_s) begin
            guard_d = '0;
          end else if (guard_q == GW'(GUARD - 1)) begin
            state_d = WAIT_START;
            guard_d = '0;
          end else begin
            guard_d = guard_q + 1'b1;
          end
        end
        WAIT_START: begin
          if (fall) begin
            state_d = MEASURE;
            cnt_d   = '0;
            edges_d = 3'd1;
          end else begin
            state_d = WAIT_START;
          end
        end
        MEASURE: begin
          if (cnt_q == CNT_MAX) begin
            state_d = FAIL;
          end else if (fall && (edges_q == 3'(SYNC_EDGES - 1))) begin
            meas_d  = cnt_q + 1'b1;
            cnt_d   = '0;
            edges_d = 3'(SYNC_EDGES);
            state_d = STOP_CHK;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
              edges_d = edges_q + 3'd1;
            end else begin
              edges_d = edges_q;
            end
          end
        end
        STOP_CHK: begin
          // Sample RX mid stop bit, 1.5 bit times after the fifth edge.
          if (cnt_q == stop_t_s) begin
            if (rx_s && q_ok_s) begin
              state_d = LOCK;
            end else begin
              state_d = FAIL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCK: begin
          divisor_d   = rnd_s[DIV_W-1:0];
          locked_d    = 1'b1;
          busy_d      = 1'b0;
          en_pend_d   = 1'b1;
          div_valid_d = 1'b1;
          state_d     = IDLE;
        end
        FAIL: begin
          err_d     = 1'b1;
          busy_d    = 1'b0;
          baud_en_d = div_valid_q;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      guard_q     <= '0;
      cnt_q       <= '0;
      meas_q      <= '0;
      edges_q     <= 3'd0;
      divisor_q   <= '0;
      baud_en_q   <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      en_pend_q   <= 1'b0;
      div_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      cnt_q       <= cnt_d;
      meas_q      <= meas_d;
      edges_q     <= edges_d;
      divisor_q   <= divisor_d;
      baud_en_q   <= baud_en_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      en_pend_q   <= en_pend_d;
      div_valid_q <= div_valid_d;
    end
  end

  assign divisor = divisor_q;
  assign baud_en = baud_en_q;
  assign locked  = locked_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: directed 0x55 frames and host writes, with
// an output-level model compared on every falling clock edge.
module tb_uart_autobaud_ctrl;

  // Narrow divisor keeps counter saturation and overflow reachable quickly.
  localparam int DIV_W    = 6;
  localparam int OSR_LOG2 = 4;
  localparam int GUARD    = 16;
  localparam int S        = 3 + OSR_LOG2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx = 1'b1;
  logic             start = 1'b0;
  logic             manual_wr = 1'b0;
  logic [DIV_W-1:0] manual_div = '0;
  logic [DIV_W-1:0] divisor;
  logic             baud_en, locked, busy, err;

  uart_autobaud_ctrl #(.DIV_W(DIV_W), .OSR_LOG2(OSR_LOG2), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .start(start), .manual_wr(manual_wr),
    .manual_div(manual_div), .divisor(divisor), .baud_en(baud_en),
    .locked(locked), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DIV_W-1:0] m_div = '0;
  logic m_en = 1'b0, m_locked = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic m_valid = 1'b0;
  logic [DIV_W-1:0] prev_div = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Output model check on every cycle, plus the divisor-change rule.
  always @(negedge clk) begin
    check("divisor", 32'(divisor), 32'(m_div));
    check("baud_en", 32'(baud_en), 32'(m_en));
    check("locked",  32'(locked),  32'(m_locked));
    check("busy",    32'(busy),    32'(m_busy));
    check("err",     32'(err),     32'(m_err));
    if (divisor !== prev_div) check("div_change_with_en_low", 32'(baud_en), 32'd0);
    prev_div = divisor;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int exp_q(input int p);
    int meas;
    meas = 8 * p;
    return (meas + (1 << (S - 1))) >> S;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_busy = 1'b1; m_en = 1'b0; m_locked = 1'b0; m_err = 1'b0;
  endtask

  task automatic send_frame(input int p, input bit stop_high);
    logic [7:0] ch;
    ch = 8'h55;
    rx = 1'b0;
    repeat (p) tick();
    for (int i = 0; i < 8; i++) begin
      rx = ch[i];
      repeat (p) tick();
    end
    rx = stop_high;
    repeat (p) tick();
    rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic await_done(input int budget, input bit exp_lock, input logic [DIV_W-1:0] q);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", 32'(n < budget), 32'd1);
    m_busy = 1'b0;
    if (exp_lock) begin
      m_div = q; m_locked = 1'b1; m_err = 1'b0; m_en = 1'b0; m_valid = 1'b1;
      tick();
      m_en = 1'b1;
    end else begin
      m_err = 1'b1;
      m_en  = m_valid;
    end
  endtask

  task automatic autobaud(input int p, input bit stop_high);
    int q;
    bit ok;
    q  = exp_q(p);
    ok = stop_high && (q != 0) && (q <= (1 << DIV_W) - 1);
    pulse_start();
    repeat (GUARD + 8) tick();
    fork
      send_frame(p, stop_high);
      await_done(12 * p + 200, ok, q[DIV_W-1:0]);
    join
    repeat (10) tick();
  endtask

  task automatic enter_measure();
    pulse_start();
    repeat (GUARD + 8) tick();
    rx = 1'b0;
    repeat (50) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", {26'd0, divisor, baud_en, locked, busy, err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Stop bit held low with no prior divisor: error, generator stays off.
    autobaud(868, 1'b0);
    check("stoplow_err", 32'(err), 32'd1);
    check("stoplow_div", 32'(divisor), 32'd0);
    check("stoplow_en",  32'(baud_en), 32'd0);

    autobaud(868, 1'b1);
    check("p868_div", 32'(divisor), 32'd54);
    check("p868_locked", 32'(locked), 32'd1);
    check("p868_en", 32'(baud_en), 32'd1);

    autobaud(1015, 1'b1);
    check("p1015_div_max", 32'(divisor), 32'd63);

    // Rounded value 64 does not fit six bits.
    autobaud(1016, 1'b1);
    check("p1016_overflow_err", 32'(err), 32'd1);
    check("p1016_div_kept", 32'(divisor), 32'd63);
    check("p1016_en_prev_valid", 32'(baud_en), 32'd1);

    autobaud(4, 1'b1);
    check("p4_q0_err", 32'(err), 32'd1);
    check("p4_div_kept", 32'(divisor), 32'd63);

    // Single edge then RX low: counter saturates; a start mid-measure is ignored.
    enter_measure();
    start = 1'b1;
    tick();
    start = 1'b0;
    await_done(9000, 1'b0, '0);
    rx = 1'b1;
    check("sat_err", 32'(err), 32'd1);
    check("sat_busy", 32'(busy), 32'd0);
    repeat (10) tick();

    // Host write during measurement, with a coincident start.
    enter_measure();
    manual_wr = 1'b1; manual_div = 6'd27; start = 1'b1;
    tick();
    manual_wr = 1'b0; start = 1'b0;
    m_div = 6'd27; m_en = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_valid = 1'b1;
    check("manual_div_now", 32'(divisor), 32'd27);
    check("manual_en_low_now", 32'(baud_en), 32'd0);
    tick();
    m_en = 1'b1; m_locked = 1'b1;
    check("manual_en_next", 32'(baud_en), 32'd1);
    rx = 1'b1;
    repeat (40) tick();
    check("manual_start_ignored", 32'(busy), 32'd0);

    manual_wr = 1'b1; manual_div = 6'd0;
    tick();
    manual_wr = 1'b0;
    m_err = 1'b1;
    check("manual_zero_err", 32'(err), 32'd1);
    check("manual_zero_div", 32'(divisor), 32'd27);
    repeat (3) tick();

    manual_wr = 1'b1; manual_div = 6'd40;
    tick();
    manual_wr = 1'b0;
    m_div = 6'd40; m_en = 1'b0; m_err = 1'b0;
    tick();
    m_en = 1'b1;
    repeat (3) tick();
    check("manual40_div", 32'(divisor), 32'd40);

    // Reset in the middle of a measurement.
    enter_measure();
    rst_n = 1'b0;
    m_div = '0; m_en = 1'b0; m_locked = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_valid = 1'b0;
    #1;
    check("midrst_outputs", {26'd0, divisor, baud_en, locked, busy, err}, 32'd0);
    repeat (3) tick();
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_rst_outputs", {26'd0, divisor, baud_en, locked, busy, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
Configuration controller for the UART baud-rate generator. Measures an incoming 0x55 sync character on the RX line, computes the divisor, and loads it. It gates the generator's enable while the divisor is invalid or changing. A host manual-divisor write overrides the measurement.

Parameters:
DIV_W, 16, divisor width; matches the baud generator divisor port.
OSR_LOG2, 4, log2 of the generator oversampling rate (16x).
GUARD, 16, clk cycles RX must be idle-high before the start edge is armed.
CNT_W, DIV_W+3+OSR_LOG2, measurement counter width (derived; do not override).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  raw asynchronous UART RX line
start  in  1  one-cycle pulse: begin autobaud
manual_wr  in  1  one-cycle pulse: load manual_div
manual_div  in  DIV_W  host divisor
divisor  out  DIV_W  divisor to baud generator
baud_en  out  1  enable to baud generator
locked  out  1  divisor valid
busy  out  1  autobaud in progress
err  out  1  sticky autobaud failure

Behaviour:
- Reset (clk, rst_n asynchronous active-low): divisor=0, baud_en=0, locked=0, busy=0, err=0, state=IDLE, counters 0. Reset mid-operation aborts to these values immediately.
- rx goes through a 2-FF synchronizer. A falling edge is rx_s=0 with the previous rx_s=1, giving +2 cycles of latency, equal for all edges.
- S = 3+OSR_LOG2.
- States:
  - IDLE: on start -> ARM; busy=1, baud_en=0, locked=0, err=0.
  - ARM: a guard counter counts consecutive rx_s=1 cycles and clears on rx_s=0. On reaching GUARD -> WAIT_START.
  - WAIT_START: first falling edge -> MEASURE; cnt=0, edges=1.
  - MEASURE: cnt increments each cycle and saturates at 2^CNT_W-1. Each falling edge increments edges. On edge 5, capture meas=cnt (cycles from edge 1 to edge 5 = 8 bit times) -> STOP_CHK. Saturation -> FAIL.
  - STOP_CHK: wait T=(meas>>3)+(meas>>4) cycles (1.5 bit), then sample rx_s. If 1 -> compute; if 0 -> FAIL.
  - Compute: q=(meas+2^(S-1))>>S, truncated to DIV_W.
    - q=0, or the rounded value exceeds 2^DIV_W-1 -> FAIL.
    - Otherwise -> LOCK.
  - LOCK (1 cycle): divisor<=q, locked<=1, busy<=0; baud_en<=1 the following cycle -> IDLE.
  - FAIL (1 cycle): err<=1, busy<=0, divisor unchanged. baud_en<=1 if a valid divisor existed before start (locked_prev), else stays 0 -> IDLE.
- manual_wr, any state: abort autobaud -> IDLE; busy=0, err=0.
  - Cycle N: baud_en<=0, divisor<=manual_div.
  - Cycle N+1: baud_en<=1, locked<=1.
  - manual_div=0: divisor not updated, err<=1, baud_en and locked unchanged.
- start while busy: ignored.
- start and manual_wr in the same cycle: manual_wr wins.
- The divisor output only changes while baud_en=0. baud_en re-asserts exactly one cycle after any divisor change.
- err is sticky; it clears only on an accepted start or a valid manual_wr.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, ARM, WAIT_START, MEASURE, STOP_CHK, LOCK, FAIL)
  - SYNC_CHAR=8'h55
  - SYNC_EDGES=5
  - BITS_MEASURED=8
- One sub-module, uart_rx_sync: 2-FF synchronizer plus registered falling-edge detector (outputs rx_s, fall).
- The FSM, counters and divisor arithmetic stay in uart_autobaud_ctrl.

Test Plan:
- 0x55 sent with an 868-cycle bit period after start -> meas=6944, divisor=54, locked=1, busy=0, err=0; baud_en=1 one cycle after divisor update.
- 0x55 with a 10417-cycle bit period -> meas=83336, divisor=651, locked=1.
- Bit period 868, rx held low through the stop bit -> err=1, locked=0, divisor=0, baud_en=0.
- After start, single falling edge then rx held low -> cnt saturates at 8388607 -> err=1, busy=0.
- 0x55 with a 4-cycle bit period -> meas=32, q=0 -> err=1, divisor unchanged.
- manual_wr with manual_div=27 during MEASURE -> busy=0; divisor=27 with baud_en=0 that cycle; baud_en=1 and locked=1 next cycle. A start pulse in the manual_wr cycle has no effect. A later reset mid-MEASURE -> all outputs 0.
